packet_header_dec: RTL and testbench

Tier-2 packet header decoder: the receive-side counterpart of `packet_header`. It parses a JPEG2000 packet header byte stream for a single-layer, single-code-block precinct. It removes bit stuffing and recovers the empty flag, zero-bitplane count, coding-pass count and codeword length. It sits between the codestream byte source and the tier-1 (MQ) decode path, and its outputs match the encoder's `zero_bitplanes` / `pass_num` / `codeword_len` inputs.

---
 rtl/jpc_t2_pkg.sv | 42 ++++
 rtl/phd_bit_reader.sv | 64 ++++++
 rtl/packet_header_dec.sv | 227 ++++++++++++++++++++++
 tb/tb_packet_header_dec.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jpc_t2_pkg.sv
// Shared tier-2 definitions: parser state encoding, NPASS codeword prefix
// bases, initial Lblock value and a small floor(log2) helper.
package jpc_t2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_NONEMPTY,
    ST_INCL,
    ST_ZBP,
    ST_NPASS,
    ST_LBLK,
    ST_LEN,
    ST_ALIGN,
    ST_DONE
  } phd_state_t;

  // Position inside an NPASS codeword: two single prefix bits, then one of
  // the 2/5/7-bit value fields.
  typedef enum logic [2:0] {
    NP_B0,
    NP_B1,
    NP_F2,
    NP_F5,
    NP_F7
  } npass_phase_t;

  localparam logic [7:0] NPASS_BASE_2B = 8'd3;
  localparam logic [7:0] NPASS_BASE_5B = 8'd6;
  localparam logic [7:0] NPASS_BASE_7B = 8'd37;
  localparam logic [7:0] NPASS_MAX     = 8'd164;
  localparam logic [7:0] LBLOCK_INIT   = 8'd3;

  function automatic logic [2:0] floor_log2_8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/phd_bit_reader.sv
// Header bit reader: byte handshake, removal of the stuffed MSB after 0xFF,
// bit counter, end-of-header alignment and accepted-byte count.
module phd_bit_reader (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        fetch_en,
  input  logic        bit_take,
  input  logic        align_req,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  output logic        byte_in_ready,
  output logic        bit_valid,
  output logic        bit_val,
  output logic        stuff_err,
  output logic        align_done,
  output logic        align_err,
  output logic [15:0] byte_cnt
);

  logic [7:0] byte_q;
  logic [3:0] cnt;
  logic       last_ff;
  logic [2:0] bit_idx;
  logic       xfer;

  // cnt counts bits still to deliver; a stuffed byte starts at 7 so bit 7 is skipped
  assign bit_idx       = cnt[2:0] - 3'd1;
  assign bit_valid     = (cnt != 4'd0);
  assign bit_val       = byte_q[bit_idx];
  // while aligning, a byte is only wanted when the last byte was 0xFF
  assign byte_in_ready = (fetch_en & ~bit_valid) | (align_req & last_ff);
  assign xfer          = byte_in_valid & byte_in_ready;
  assign stuff_err     = fetch_en & xfer & last_ff & byte_in[7];
  assign align_done    = align_req & (~last_ff | byte_in_valid);
  assign align_err     = align_req & last_ff & xfer & (byte_in != 8'h00);

  // byte load, bit consumption, alignment flush and byte counting
  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_q   <= 8'h00;
      cnt      <= 4'd0;
      last_ff  <= 1'b0;
      byte_cnt <= 16'd0;
    end else if (clear) begin
      cnt      <= 4'd0;
      last_ff  <= 1'b0;
      byte_cnt <= 16'd0;
    end else begin
      if (xfer) byte_cnt <= byte_cnt + 16'd1;
      if (align_req) begin
        cnt <= 4'd0;
        if (xfer) last_ff <= 1'b0;
      end else if (xfer) begin
        byte_q  <= byte_in;
        cnt     <= last_ff ? 4'd7 : 4'd8;
        last_ff <= (byte_in == 8'hFF);
      end else if (bit_take) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/packet_header_dec.sv
// Tier-2 packet header decoder for a single-layer, single-code-block precinct.
// Recovers empty flag, zero-bitplane count, coding passes and codeword length.
// Optional build macro JPC_PHD_ERROR_CHECK_EN enables stream error detection;
// without it `error` stays 0 and fields decode as-is.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for go
// ST_NONEMPTY | first bit: 0 = empty packet
// ST_INCL     | single-node inclusion tag tree bit
// ST_ZBP      | counting zero-bitplane 0s up to the terminating 1
// ST_NPASS    | coding-pass codeword (prefix bits, then 2/5/7-bit value)
// ST_LBLK     | Lblock increments (1s) until the terminating 0
// ST_LEN      | Lblock + floor(log2(passes)) length bits, MSB first
// ST_ALIGN    | drop rest of byte; eat 0x00 after a final 0xFF
// ST_DONE     | done pulse cycle
module packet_header_dec
  import jpc_t2_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             go,
  input  logic [7:0]       byte_in,
  input  logic             byte_in_valid,
  output logic             byte_in_ready,
  output logic             done,
  output logic             empty_packet,
  output logic [7:0]       zero_bitplanes,
  output logic [7:0]       pass_num,
  output logic [LEN_W-1:0] codeword_len,
  output logic [15:0]      hdr_bytes,
  output logic             error
);

`ifdef JPC_PHD_ERROR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  phd_state_t   state;
  npass_phase_t np_phase;
  logic [6:0]   field;
  logic [2:0]   fcnt;
  logic [7:0]   lblock;
  logic [8:0]   len_left;

  logic         parse;
  logic         bit_take;
  logic         bit_valid;
  logic         bit_val;
  logic         stuff_err;
  logic         align_done;
  logic         align_err;
  logic [6:0]   field_nx;
  logic [8:0]   len_bits;
  logic [7:0]   pass_7b;

  assign parse    = (state inside {ST_NONEMPTY, ST_INCL, ST_ZBP, ST_NPASS, ST_LBLK, ST_LEN});
  assign bit_take = parse & bit_valid;
  assign field_nx = {field[5:0], bit_val};
  assign len_bits = {1'b0, lblock} + {6'd0, floor_log2_8(pass_num)};
  assign pass_7b  = NPASS_BASE_7B + {1'b0, field_nx};

  phd_bit_reader u_reader (
    .clk           (clk),
    .rstn          (rstn),
    .clear         ((state == ST_IDLE) & go),
    .fetch_en      (parse),
    .bit_take      (bit_take),
    .align_req     (state == ST_ALIGN),
    .byte_in       (byte_in),
    .byte_in_valid (byte_in_valid),
    .byte_in_ready (byte_in_ready),
    .bit_valid     (bit_valid),
    .bit_val       (bit_val),
    .stuff_err     (stuff_err),
    .align_done    (align_done),
    .align_err     (align_err),
    .byte_cnt      (hdr_bytes)
  );

  // header parser: one bit per cycle while the reader holds bits
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      np_phase       <= NP_B0;
      field          <= 7'd0;
      fcnt           <= 3'd0;
      lblock         <= 8'd0;
      len_left       <= 9'd0;
      done           <= 1'b0;
      empty_packet   <= 1'b0;
      zero_bitplanes <= 8'd0;
      pass_num       <= 8'd0;
      codeword_len   <= '0;
      error          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            state          <= ST_NONEMPTY;
            np_phase       <= NP_B0;
            lblock         <= LBLOCK_INIT;
            empty_packet   <= 1'b0;
            zero_bitplanes <= 8'd0;
            pass_num       <= 8'd0;
            codeword_len   <= '0;
            error          <= 1'b0;
          end
        end
        ST_ALIGN: begin
          if (CHECK_EN && align_err) error <= 1'b1;
          if (align_done) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          if (CHECK_EN && stuff_err) begin
            error <= 1'b1;
            state <= ST_ALIGN;
          end else if (bit_valid) begin
            case (state)
              ST_NONEMPTY: begin
                if (bit_val) state <= ST_INCL;
                else begin
                  empty_packet <= 1'b1;
                  state        <= ST_ALIGN;
                end
              end
              ST_INCL: begin
                if (CHECK_EN && !bit_val) begin
                  error <= 1'b1;
                  state <= ST_ALIGN;
                end else begin
                  state <= ST_ZBP;
                end
              end
              ST_ZBP: begin
                if (bit_val) state <= ST_NPASS;
                else zero_bitplanes <= zero_bitplanes + 8'd1;
              end
              ST_NPASS: begin
                case (np_phase)
                  NP_B0: begin
                    if (bit_val) np_phase <= NP_B1;
                    else begin
                      pass_num <= 8'd1;
                      state    <= ST_LBLK;
                    end
                  end
                  NP_B1: begin
                    if (bit_val) begin
                      np_phase <= NP_F2;
                      field    <= 7'd0;
                      fcnt     <= 3'd2;
                    end else begin
                      pass_num <= 8'd2;
                      state    <= ST_LBLK;
                    end
                  end
                  default: begin
                    if (fcnt != 3'd1) begin
                      field <= field_nx;
                      fcnt  <= fcnt - 3'd1;
                    end else if (np_phase == NP_F2) begin
                      // an all-ones value field is the escape to the next, longer field
                      if (field_nx[1:0] == 2'b11) begin
                        np_phase <= NP_F5;
                        field    <= 7'd0;
                        fcnt     <= 3'd5;
                      end else begin
                        pass_num <= NPASS_BASE_2B + {6'd0, field_nx[1:0]};
                        state    <= ST_LBLK;
                      end
                    end else if (np_phase == NP_F5) begin
                      if (field_nx[4:0] == 5'h1F) begin
                        np_phase <= NP_F7;
                        field    <= 7'd0;
                        fcnt     <= 3'd7;
                      end else begin
                        pass_num <= NPASS_BASE_5B + {3'd0, field_nx[4:0]};
                        state    <= ST_LBLK;
                      end
                    end else begin
                      pass_num <= pass_7b;
                      if (CHECK_EN && (pass_7b > NPASS_MAX)) begin
                        error <= 1'b1;
                        state <= ST_ALIGN;
                      end else begin
                        state <= ST_LBLK;
                      end
                    end
                  end
                endcase
              end
              ST_LBLK: begin
                if (bit_val) begin
                  if (lblock != 8'hFF) lblock <= lblock + 8'd1;
                end else if (CHECK_EN && (len_bits > 9'(LEN_W))) begin
                  error <= 1'b1;
                  state <= ST_ALIGN;
                end else begin
                  len_left     <= len_bits;
                  codeword_len <= '0;
                  state        <= ST_LEN;
                end
              end
              ST_LEN: begin
                codeword_len <= {codeword_len[LEN_W-2:0], bit_val};
                len_left     <= len_left - 9'd1;
                if (len_left == 9'd1) state <= ST_ALIGN;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_header_dec.sv
// Bench for packet_header_dec: directed vectors plus randomized headers built
// by a field-level encoder model (bit packing with 0xFF stuffing).
module tb_packet_header_dec;

  localparam int LEN_W = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit empty;
    int zbp;
    int pass;
    int lblock;
    int len;
  } hdr_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             go;
  logic [7:0]       byte_in;
  logic             byte_in_valid;
  logic             byte_in_ready;
  logic             done;
  logic             empty_packet;
  logic [7:0]       zero_bitplanes;
  logic [7:0]       pass_num;
  logic [LEN_W-1:0] codeword_len;
  logic [15:0]      hdr_bytes;
  logic             error;

  int n_cmp = 0;
  int n_bad = 0;
  bit enc_bits[$];

  always #5 clk = ~clk;

  packet_header_dec #(.LEN_W(LEN_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .go             (go),
    .byte_in        (byte_in),
    .byte_in_valid  (byte_in_valid),
    .byte_in_ready  (byte_in_ready),
    .done           (done),
    .empty_packet   (empty_packet),
    .zero_bitplanes (zero_bitplanes),
    .pass_num       (pass_num),
    .codeword_len   (codeword_len),
    .hdr_bytes      (hdr_bytes),
    .error          (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int flog2(input int p);
    int l = 0;
    while ((1 << (l + 1)) <= p) l++;
    return l;
  endfunction

  function automatic void push_val(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) enc_bits.push_back(bit'((v >> i) & 1));
  endfunction

  // field-level encoder: header bits, then byte packing with stuffing and padding
  function automatic void encode(input hdr_t h, output bq_t bytes, output int nbits, output int ndata);
    int cur, k, cap, p;
    bit prev_ff;
    enc_bits.delete();
    if (h.empty) push_val(0, 1);
    else begin
      push_val(3, 2);
      push_val(1, h.zbp + 1);
      p = h.pass;
      if (p == 1)       push_val(0, 1);
      else if (p == 2)  push_val(2, 2);
      else if (p <= 5)  begin push_val(3, 2);   push_val(p - 3, 2);  end
      else if (p <= 36) begin push_val(15, 4);  push_val(p - 6, 5);  end
      else              begin push_val(511, 9); push_val(p - 37, 7); end
      push_val(((1 << (h.lblock - 3)) - 1) << 1, h.lblock - 2);
      push_val(h.len, h.lblock + flog2(p));
    end
    nbits = enc_bits.size();
    bytes.delete();
    prev_ff = 1'b0; cur = 0; k = 0; cap = 8;
    foreach (enc_bits[i]) begin
      cur = (cur << 1) | int'(enc_bits[i]);
      k++;
      if (k == cap) begin
        bytes.push_back(8'(cur));
        prev_ff = (cur == 255);
        cap = prev_ff ? 7 : 8;
        cur = 0; k = 0;
      end
    end
    if (k > 0) begin
      cur = cur << (cap - k);
      bytes.push_back(8'(cur));
      prev_ff = (cur == 255);
    end
    ndata = bytes.size();
    if (prev_ff) bytes.push_back(8'h00);
  endfunction

  task automatic run_packet(input bq_t bytes, input int stall_pct, input int go_mid_at,
                            input int abort_at, output int lat, output int stalls, output bit got);
    bq_t q;
    int cyc;
    bit xfer;
    q = bytes; stalls = 0; got = 1'b0; cyc = 0;
    @(negedge clk); go = 1'b1; byte_in_valid = 1'b0;
    @(negedge clk); go = 1'b0;
    while (!got && cyc < 400) begin
      if (abort_at != 0 && cyc == abort_at) begin
        rstn = 1'b0;
        break;
      end
      go = (go_mid_at != 0 && cyc == go_mid_at);
      if (q.size() > 0 && $urandom_range(0, 99) >= stall_pct) begin
        byte_in_valid = 1'b1;
        byte_in = q[0];
      end else begin
        byte_in_valid = 1'b0;
      end
      xfer = byte_in_valid && byte_in_ready;
      if (byte_in_ready && !byte_in_valid) stalls++;
      @(posedge clk);
      if (xfer) void'(q.pop_front());
      @(negedge clk);
      go = 1'b0; byte_in_valid = 1'b0;
      cyc++;
      if (done === 1'b1) got = 1'b1;
    end
    lat = cyc;
  endtask

  task automatic check_result(input string tag, input bit got, input int lat, input int exp_lat,
                              input bit exp_empty, input int exp_zbp, input int exp_pass,
                              input int exp_len, input int exp_hdr, input bit exp_err,
                              input bit chk_fields);
    check({tag, ".done"}, 32'(got), 32'd1);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".empty"}, 32'(empty_packet), 32'(exp_empty));
    check({tag, ".hdr_bytes"}, 32'(hdr_bytes), exp_hdr);
    check({tag, ".error"}, 32'(error), 32'(exp_err));
    if (chk_fields) begin
      check({tag, ".zbp"}, 32'(zero_bitplanes), exp_zbp);
      check({tag, ".pass"}, 32'(pass_num), exp_pass);
      check({tag, ".len"}, 32'(codeword_len), exp_len);
    end
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    if (chk_fields) check({tag, ".hold_len"}, 32'(codeword_len), exp_len);
  endtask

  initial begin
    bq_t  v1, bytes;
    hdr_t h;
    int   lat, stalls, nbits, ndata, lg;
    bit   got;

    v1 = '{8'hDF, 8'h87, 8'hE8, 8'h71, 8'h80};
    rstn = 1'b0; go = 1'b0; byte_in = 8'h00; byte_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.done", 32'(done), 0);
    check("rst.ready", 32'(byte_in_ready), 0);
    check("rst.pass", 32'(pass_num), 0);
    check("rst.len", 32'(codeword_len), 0);
    check("rst.hdr", 32'(hdr_bytes), 0);
    rstn = 1'b1;

    run_packet(v1, 0, 0, 0, lat, stalls, got);
    check_result("vec1", got, lat, 39, 0, 1, 22, 4323, 5, 0, 1);

    bytes = '{8'hE5};
    run_packet(bytes, 0, 0, 0, lat, stalls, got);
    check_result("e5", got, lat, 10, 0, 0, 1, 5, 1, 0, 1);

    bytes = '{8'h00};
    run_packet(bytes, 0, 0, 0, lat, stalls, got);
    check_result("empty", got, lat, 3, 1, 0, 0, 0, 1, 0, 0);

    // stuffed byte mid-header, maximum pass count
    bytes = '{8'hFF, 8'h7F, 8'hF5, 8'h4A};
    run_packet(bytes, 0, 0, 0, lat, stalls, got);
    check_result("stuff", got, lat, 35, 0, 0, 164, 677, 4, 0, 1);

    // header ending in 0xFF needs the trailing 0x00
    bytes = '{8'hEF, 8'hF7, 8'hFF, 8'h00};
    run_packet(bytes, 0, 0, 0, lat, stalls, got);
    check_result("fftail", got, lat, 28, 0, 0, 1, 2047, 4, 0, 1);

    // stalls plus a go pulse while busy
    run_packet(v1, 35, 5, 0, lat, stalls, got);
    check_result("vec1_stall", got, lat - stalls, 39, 0, 1, 22, 4323, 5, 0, 1);

    run_packet(v1, 0, 0, 12, lat, stalls, got);
    check("abort.no_done", 32'(got), 0);
    @(negedge clk);
    check("abort.done", 32'(done), 0);
    check("abort.zbp", 32'(zero_bitplanes), 0);
    check("abort.hdr", 32'(hdr_bytes), 0);
    check("abort.ready", 32'(byte_in_ready), 0);
    rstn = 1'b1;
    run_packet(v1, 0, 0, 0, lat, stalls, got);
    check_result("vec1_after_rst", got, lat, 39, 0, 1, 22, 4323, 5, 0, 1);

`ifdef JPC_PHD_ERROR_CHECK_EN
    bytes = '{8'hFF, 8'h80};
    run_packet(bytes, 0, 0, 0, lat, stalls, got);
    check_result("err_stuff", got, lat, 11, 0, 0, 0, 0, 2, 1, 0);
    bytes = '{8'h80};
    run_packet(bytes, 0, 0, 0, lat, stalls, got);
    check_result("err_incl", got, lat, 4, 0, 0, 0, 0, 1, 1, 0);
    bytes = '{8'hEF, 8'hFF, 8'h60};
    run_packet(bytes, 0, 0, 0, lat, stalls, got);
    check_result("err_lblk", got, lat, 23, 0, 0, 0, 0, 3, 1, 0);
    bytes = '{8'hEF, 8'hF7, 8'hFF, 8'h01};
    run_packet(bytes, 0, 0, 0, lat, stalls, got);
    check_result("err_align", got, lat, 28, 0, 0, 0, 0, 4, 1, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      h.empty = ($urandom_range(0, 7) == 0);
      h.zbp   = $urandom_range(0, 12);
      case ($urandom_range(0, 4))
        0:       h.pass = 1;
        1:       h.pass = 2;
        2:       h.pass = $urandom_range(3, 5);
        3:       h.pass = $urandom_range(6, 36);
        default: h.pass = $urandom_range(37, 164);
      endcase
      lg       = flog2(h.pass);
      h.lblock = $urandom_range(3, LEN_W - lg);
      h.len    = $urandom_range(0, (1 << (h.lblock + lg)) - 1);
      encode(h, bytes, nbits, ndata);
      run_packet(bytes, (n % 2) * 25, 0, 0, lat, stalls, got);
      check_result($sformatf("rnd%0d", n), got, lat - stalls, ndata + nbits + 1, h.empty,
                   h.zbp, h.pass, h.len, bytes.size(), 0, !h.empty);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
